// File: rtl/histogram_accumulator.sv
// rtl/histogram_accumulator.sv - per-bin saturating histogram with RMW pipeline, host read and clear
// Optional feature macro: HIST_OVERFLOW_FLAG_EN (sticky bin-saturation flag on ovf).
module histogram_accumulator #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] Addr,
  input  logic              Memory_add,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [CNT_W-1:0]  rd_data,
  output logic              rd_valid,
  input  logic              clr_start,
  output logic              busy,
  output logic [15:0]       drop_cnt,
  output logic              ovf
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {ST_IDLE, ST_DRAIN, ST_CLEAR} state_t;

  state_t              state_q, state_d;
  logic                ms1_q, ms2_q, ms3_q;
  logic                edge_det, ev_accept, ev_drop;
  logic [ADDR_W-1:0]   ev_addr_q;
  logic                s1_vld_q, s2_vld_q;
  logic [ADDR_W-1:0]   s2_addr_q;
  logic [CNT_W-1:0]    s2_data_q;
  logic [CNT_W-1:0]    s1_base, s1_sum;
  logic                rd_accept, rd_issue, pend_q, rd_iss_q;
  logic [ADDR_W-1:0]   pend_addr_q, host_addr;
  logic [CNT_W-1:0]    rd_data_q;
  logic                rd_valid_q;
  logic [15:0]         drop_q;
  logic [ADDR_W-1:0]   clr_addr_q;
  logic                clr_we, clr_last, pipe_empty;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_waddr, ram_raddr;
  logic [CNT_W-1:0]    ram_wdata, ram_rdata_q;
  logic [CNT_W-1:0]    mem_q [0:DEPTH-1];

  // The strobe is asynchronous; an event is its synchronised rising edge.
  assign edge_det  = ms2_q & ~ms3_q;
  assign ev_accept = edge_det && (state_q == ST_IDLE);
  assign ev_drop   = edge_det && (state_q != ST_IDLE);

  // Host reads: one-deep pending slot; the event read (S0) always wins the read port.
  assign rd_accept = rd_req && (state_q == ST_IDLE) && !clr_start && !pend_q;
  assign rd_issue  = !ev_accept && (pend_q || rd_accept);
  assign host_addr = pend_q ? pend_addr_q : rd_addr;

  // S0 is the edge cycle itself: Addr is stable there, so it addresses the RAM directly.
  assign ram_raddr = ev_accept ? Addr : host_addr;
  assign ram_we    = s2_vld_q || clr_we;
  assign ram_waddr = clr_we ? clr_addr_q : s2_addr_q;
  assign ram_wdata = clr_we ? '0 : s2_data_q;

  // S1: the read done in S0 missed a write S2 is doing now to the same bin; take it instead.
  assign s1_base = (s2_vld_q && (s2_addr_q == ev_addr_q)) ? s2_data_q : ram_rdata_q;
  assign s1_sum  = (s1_base == {CNT_W{1'b1}}) ? s1_base : s1_base + CNT_W'(1);

  assign pipe_empty = !s1_vld_q && !s2_vld_q && !ev_accept;

  // 2-FF synchroniser plus one delayed copy for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ms1_q <= 1'b0;
      ms2_q <= 1'b0;
      ms3_q <= 1'b0;
    end else begin
      ms1_q <= Memory_add;
      ms2_q <= ms1_q;
      ms3_q <= ms2_q;
    end
  end

  // RMW pipeline registers: S1 holds the captured bin, S2 holds the value to write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ev_addr_q <= '0;
      s1_vld_q  <= 1'b0;
      s2_vld_q  <= 1'b0;
      s2_addr_q <= '0;
      s2_data_q <= '0;
    end else begin
      if (edge_det) ev_addr_q <= Addr;
      s1_vld_q  <= ev_accept;
      s2_vld_q  <= s1_vld_q;
      s2_addr_q <= ev_addr_q;
      s2_data_q <= s1_sum;
    end
  end

  // Histogram RAM: one write and one read per cycle; a same-cycle write to the read bin is forwarded
  always_ff @(posedge clk) begin
    if (ram_we) mem_q[ram_waddr] <= ram_wdata;
    ram_rdata_q <= (ram_we && (ram_waddr == ram_raddr)) ? ram_wdata : mem_q[ram_raddr];
  end

  // Host read path: pending slot, issue marker, then registered result two cycles after issue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      rd_iss_q    <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      if (rd_issue && pend_q) begin
        pend_q <= 1'b0;
      end else if (rd_accept && ev_accept) begin
        pend_q      <= 1'b1;
        pend_addr_q <= rd_addr;
      end
      rd_iss_q   <= rd_issue;
      rd_valid_q <= rd_iss_q;
      if (rd_iss_q) rd_data_q <= ram_rdata_q;
    end
  end

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

  // Count events lost while busy, saturating
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_q <= '0;
    end else if (ev_drop && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign drop_cnt = drop_q;

  // Clear FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Clear FSM next state: drain in-flight increments before wiping
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (clr_start) state_d = pipe_empty ? ST_CLEAR : ST_DRAIN;
      ST_DRAIN: if (!s1_vld_q && !s2_vld_q) state_d = ST_CLEAR;
      ST_CLEAR: if (clr_addr_q == {ADDR_W{1'b1}}) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Clear FSM outputs
  always_comb begin
    busy     = (state_q != ST_IDLE);
    clr_we   = (state_q == ST_CLEAR);
    clr_last = (state_q == ST_CLEAR) && (clr_addr_q == {ADDR_W{1'b1}});
  end

  // Wipe address walks every bin once per clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     clr_addr_q <= '0;
    else if (state_q != ST_CLEAR) clr_addr_q <= '0;
    else                         clr_addr_q <= clr_addr_q + ADDR_W'(1);
  end

`ifdef HIST_OVERFLOW_FLAG_EN
  logic ovf_q;

  // Sticky flag: set when any bin reaches full scale, dropped when a clear completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         ovf_q <= 1'b0;
    else if (clr_last)                               ovf_q <= 1'b0;
    else if (s1_vld_q && (s1_sum == {CNT_W{1'b1}})) ovf_q <= 1'b1;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_histogram_accumulator.sv
// tb/tb_histogram_accumulator.sv - scoreboard bench for histogram_accumulator
module tb_histogram_accumulator;
  localparam int ADDR_W = 8;
  localparam int CNT_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] Addr;
  logic              Memory_add;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic [CNT_W-1:0]  rd_data;
  logic              rd_valid;
  logic              clr_start;
  logic              busy;
  logic [15:0]       drop_cnt;
  logic              ovf;

  int checks  = 0;
  int errors  = 0;
  int rdv_cnt = 0;
  logic [CNT_W-1:0] exp_q[$];

`ifdef HIST_OVERFLOW_FLAG_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  always #5 clk = ~clk;

  histogram_accumulator #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .Addr(Addr), .Memory_add(Memory_add),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
    .clr_start(clr_start), .busy(busy), .drop_cnt(drop_cnt), .ovf(ovf)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_event(input logic [ADDR_W-1:0] a, input int lo);
    Addr = a;
    Memory_add = 1'b0;
    cyc(lo);
    Memory_add = 1'b1;
    cyc(3);
    Memory_add = 1'b0;
  endtask

  task automatic wait_rd_valid(output int lat);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (rd_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] a, input logic [CNT_W-1:0] e);
    int lat;
    rd_addr = a;
    rd_req  = 1'b1;
    exp_q.push_back(e);
    cyc(1);
    rd_req = 1'b0;
    wait_rd_valid(lat);
    check("rd_latency", lat, 2);
    cyc(1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 3000; i++) begin
      if (!busy) break;
      cyc(1);
    end
    check("busy_falls", busy, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  // Monitor: every rd_valid pops one expected value
  initial begin
    logic [CNT_W-1:0] e;
    forever begin
      @(negedge clk);
      if (!rst && rd_valid) begin
        rdv_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rd_unexpected: got rd_data=%0h, expected no rd_valid", rd_data);
        end else begin
          e = exp_q.pop_front();
          if (rd_data !== e) begin
            errors++;
            $display("FAIL rd_data: got %0h, expected %0h", rd_data, e);
          end
        end
      end
    end
  end

  initial begin
    int lat;
    int base;
    rst = 1'b1; Addr = '0; Memory_add = 1'b0; rd_req = 1'b0; rd_addr = '0; clr_start = 1'b0;
    cyc(3);
    check("reset_rd_data", rd_data, 0);
    check("reset_rd_valid", rd_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_drop_cnt", drop_cnt, 0);
    check("reset_ovf", ovf, 0);
    rst = 1'b0;
    cyc(2);

    // 1: clear after reset, boundary bins read zero
    clr_start = 1'b1; cyc(1); clr_start = 1'b0;
    check("t1_busy_high", busy, 1);
    wait_idle();
    do_read(8'd0, 16'd0);
    do_read(8'd128, 16'd0);
    do_read(8'd255, 16'd0);

    // 2: five slow pulses into one bin
    for (int i = 0; i < 5; i++) send_event(8'd130, 3);
    cyc(6);
    do_read(8'd130, 16'd5);
    do_read(8'd129, 16'd0);

    // 3: alternating bins at minimum spacing, then a same-bin burst
    for (int i = 0; i < 10; i++) begin
      send_event(8'd128, 2);
      send_event(8'd126, 2);
    end
    cyc(6);
    do_read(8'd128, 16'd10);
    do_read(8'd126, 16'd10);
    for (int i = 0; i < 20; i++) send_event(8'd128, 2);
    cyc(6);
    do_read(8'd128, 16'd30);

    // 4: preload bin 5 near full scale, then saturate
    force dut.ram_rdata_q = 16'hFFFD;
    send_event(8'd5, 3);
    cyc(4);
    release dut.ram_rdata_q;
    cyc(2);
    do_read(8'd5, 16'hFFFE);
    check("t4_ovf_before_sat", ovf, 0);
    for (int i = 0; i < 3; i++) send_event(8'd5, 3);
    cyc(6);
    do_read(8'd5, 16'hFFFF);
    check("t4_ovf_after_sat", ovf, OVF_EXP);

    // 6: host read lands on the event-edge cycle and must be deferred one slot
    base = rdv_cnt;
    Addr = 8'd130; Memory_add = 1'b0;
    cyc(3);
    Memory_add = 1'b1;
    cyc(2);
    rd_addr = 8'd130; rd_req = 1'b1;
    exp_q.push_back(16'd5);
    cyc(1);
    rd_req = 1'b0; Memory_add = 1'b0;
    wait_rd_valid(lat);
    check("t6_deferred_latency", lat, 3);
    cyc(6);
    check("t6_rd_valid_once", rdv_cnt - base, 1);
    do_read(8'd130, 16'd6);

    // 5: events and a read during clear are dropped; histogram ends empty
    clr_start = 1'b1; cyc(1); clr_start = 1'b0;
    check("t5_busy_high", busy, 1);
    base = rdv_cnt;
    rd_addr = 8'd3; rd_req = 1'b1; cyc(1); rd_req = 1'b0;
    for (int i = 0; i < 4; i++) send_event(8'd7, 3);
    check("t5_drop_cnt", drop_cnt, 4);
    check("t5_read_ignored", rdv_cnt - base, 0);
    wait_idle();
    check("t5_ovf_cleared", ovf, 0);
    do_read(8'd128, 16'd0);
    do_read(8'd126, 16'd0);
    do_read(8'd130, 16'd0);
    do_read(8'd5, 16'd0);
    do_read(8'd7, 16'd0);
    check("t5_drop_cnt_held", drop_cnt, 4);

    cyc(4);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
